// File: rtl/cam_init_sequencer.sv
// cam_init_sequencer: walks a fixed camera register table and issues one
// I2C write per entry through an ena/busy handshake with the I2C master.
// Delay entries (sub == 8'hFF) wait data*DELAY_UNIT clocks instead of writing.
// Optional feature macro: CAM_INIT_RETRY_EN. When defined, a NACKed entry is
// retried up to MAX_RETRY times before the sequence aborts.
module cam_init_sequencer #(
    parameter logic [7:0]  DEV_ADDR       = 8'h42,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned POWERUP_CYCLES = 50000,
    parameter int unsigned DELAY_UNIT     = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       busy,
    input  logic       ack_err,
    output logic       ena,
    output logic [7:0] addr,
    output logic       rw,
    output logic [7:0] sub_addr,
    output logic [7:0] data_wr,
    output logic [7:0] reg_idx,
    output logic       done,
    output logic       error
);

    localparam int unsigned CNT_W    = 32;
    localparam logic [7:0]  DELAY_ID = 8'hFF;
    localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        FETCH,
        WAIT_IDLE,
        REQ,
        WAIT_HI,
        WAIT_LO,
        CHECK,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         idx_d, sub_d, data_d;
    logic               ena_d, done_d, error_d;
    logic               start_pend_q, start_pend_d;
    logic               busy_m, busy_s, ack_m, ack_s;
    logic [15:0]        rom_word;
    logic [7:0]         rom_sub, rom_data;

`ifdef CAM_INIT_RETRY_EN
    logic [7:0]         retry_q, retry_d;
`else
    logic               unused_max_retry;
    assign unused_max_retry = ^32'(MAX_RETRY);
`endif

    assign addr = DEV_ADDR;
    assign rw   = 1'b0;

    // Register table: {sub_addr, data}; out-of-range indices read as zero-length delays
    always_comb begin
        case (reg_idx)
            8'd0:    rom_word = 16'h1280;
            8'd1:    rom_word = 16'h1101;
            8'd2:    rom_word = 16'h0C00;
            8'd3:    rom_word = 16'hFF02;
            8'd4:    rom_word = 16'h3E00;
            8'd5:    rom_word = 16'h40D0;
            8'd6:    rom_word = 16'h3A04;
            8'd7:    rom_word = 16'h1418;
            8'd8:    rom_word = 16'h4FB3;
            8'd9:    rom_word = 16'h50B3;
            8'd10:   rom_word = 16'h5100;
            8'd11:   rom_word = 16'h523D;
            8'd12:   rom_word = 16'h53A7;
            8'd13:   rom_word = 16'h54E4;
            8'd14:   rom_word = 16'h589E;
            8'd15:   rom_word = 16'h3DC0;
            default: rom_word = 16'hFF00;
        endcase
    end

    assign rom_sub  = rom_word[15:8];
    assign rom_data = rom_word[7:0];

    // Two-flop synchronizers for the master's data-clock-domain status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b1;
            busy_s <= 1'b1;
            ack_m  <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            busy_m <= busy;
            busy_s <= busy_m;
            ack_m  <= ack_err;
            ack_s  <= ack_m;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            reg_idx      <= '0;
            sub_addr     <= '0;
            data_wr      <= '0;
            ena          <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            start_pend_q <= 1'b0;
`ifdef CAM_INIT_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_idx      <= idx_d;
            sub_addr     <= sub_d;
            data_wr      <= data_d;
            ena          <= ena_d;
            done         <= done_d;
            error        <= error_d;
            start_pend_q <= start_pend_d;
`ifdef CAM_INIT_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = reg_idx;
        sub_d        = sub_addr;
        data_d       = data_wr;
        ena_d        = 1'b0;
        done_d       = done;
        error_d      = error;
        start_pend_d = start_pend_q;
`ifdef CAM_INIT_RETRY_EN
        retry_d      = retry_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = PWRUP;
                cnt_d   = '0;
                idx_d   = '0;
                done_d  = 1'b0;
                error_d = 1'b0;
            end
            PWRUP: begin
                if (cnt_q + 32'd1 >= 32'(POWERUP_CYCLES)) begin
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            FETCH: begin
                sub_d  = rom_sub;
                data_d = rom_data;
`ifdef CAM_INIT_RETRY_EN
                retry_d = '0;
`endif
                if (rom_sub == DELAY_ID) begin
                    state_d = DELAY;
                    cnt_d   = 32'(rom_data) * 32'(DELAY_UNIT);
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!busy_s) begin
                    state_d = REQ;
                    ena_d   = 1'b1;
                end
            end
            REQ: begin
                state_d = WAIT_HI;
                ena_d   = 1'b1;
                cnt_d   = '0;
            end
            WAIT_HI: begin
                if (busy_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end else if (cnt_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    ena_d = 1'b1;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_LO: begin
                if (!busy_s) begin
                    state_d = CHECK;
                end else if (cnt_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            CHECK: begin
                if (!ack_s) begin
                    state_d = NEXT;
`ifdef CAM_INIT_RETRY_EN
                end else if (32'(retry_q) < 32'(MAX_RETRY)) begin
                    state_d = WAIT_IDLE;
                    retry_d = retry_q + 8'd1;
`endif
                end else begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end
            end
            DELAY: begin
                // Loaded with the full cycle count; a zero count still spends one cycle here
                if (cnt_q <= 32'd1) begin
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            NEXT: begin
                if (reg_idx == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                    idx_d   = reg_idx + 8'd1;
                end
            end
            DONE, ERROR: begin
                if (start || start_pend_q) begin
                    state_d      = PWRUP;
                    cnt_d        = '0;
                    idx_d        = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    start_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start landing on the cycle we enter DONE/ERROR is replayed from the terminal state
        if (start && (state_d == DONE || state_d == ERROR) &&
            state_q != DONE && state_q != ERROR) begin
            start_pend_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Self-checking bench for cam_init_sequencer with a behavioural I2C master.
module tb_cam_init_sequencer;

    localparam int unsigned PWR  = 20;
    localparam int unsigned DU   = 10;
    localparam int unsigned TO   = 100;
    localparam int unsigned NREG = 16;
`ifdef CAM_INIT_RETRY_EN
    localparam int RETRY = 1;
    localparam int NACKS = 2;
`else
    localparam int RETRY = 0;
    localparam int NACKS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, start, busy, ack_err;
    logic       ena, rw, done, error;
    logic [7:0] addr, sub_addr, data_wr, reg_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] exp_idx;
        logic [7:0] exp_sub;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec [NREG];

    always #5 clk = ~clk;

    cam_init_sequencer #(
        .DEV_ADDR      (8'h42),
        .NUM_REGS      (NREG),
        .POWERUP_CYCLES(PWR),
        .DELAY_UNIT    (DU),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY     (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .ack_err (ack_err),
        .ena     (ena),
        .addr    (addr),
        .rw      (rw),
        .sub_addr(sub_addr),
        .data_wr (data_wr),
        .reg_idx (reg_idx),
        .done    (done),
        .error   (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] s, input logic [7:0] d);
        vec[i].exp_idx  = 8'(i);
        vec[i].exp_sub  = s;
        vec[i].exp_data = d;
    endtask

    task automatic wait_ena(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ena) ok = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One write transaction as seen by the master model
    task automatic txn(input int i, input bit nack, input bit have_ena, input bit poke);
        int cyc;
        bit ok;
        int w;
        ok = have_ena;
        if (!have_ena) wait_ena(400, cyc, ok);
        chk($sformatf("ena_seen[%0d]", i), 32'(ok), 32'd1);
        if (ok) begin
            chk($sformatf("idx[%0d]", i), 32'(reg_idx), 32'(vec[i].exp_idx));
            chk($sformatf("sub[%0d]", i), 32'(sub_addr), 32'(vec[i].exp_sub));
            chk($sformatf("data[%0d]", i), 32'(data_wr), 32'(vec[i].exp_data));
            busy    = 1'b1;
            ack_err = 1'b0;
            w = 0;
            while (ena && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("ena_width[%0d]", i), 32'(w), 32'd3);
            if (poke) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                chk("start_ignored_idx", 32'(reg_idx), 32'(vec[i].exp_idx));
                chk("start_ignored_done", 32'(done), 32'd0);
            end
            repeat (3) @(negedge clk);
            chk($sformatf("sub_hold[%0d]", i), 32'(sub_addr), 32'(vec[i].exp_sub));
            ack_err = nack;
            busy    = 1'b0;
        end
    endtask

    // Walk entries 0..last; entry nack_idx is NACKed nack_cnt times
    task automatic run_seq(input int last, input bit first_have, input bit poke,
                           input int nack_idx, input int nack_cnt);
        int  cyc;
        bit  ok;
        bit  have;
        int  n;
        int  tries;
        have = first_have;
        for (int i = 0; i <= last; i++) begin
            if (vec[i].exp_sub == 8'hFF) begin
                n = 0;
                while (sub_addr != 8'hFF && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("delay_fetch_idx", 32'(reg_idx), 32'(vec[i].exp_idx));
                chk("delay_fetch_data", 32'(data_wr), 32'(vec[i].exp_data));
                wait_ena(400, cyc, ok);
                chk_range("delay_gap", cyc, int'(vec[i].exp_data) * DU,
                          int'(vec[i].exp_data) * DU + 3);
                have = ok;
            end else begin
                n     = (i == nack_idx) ? nack_cnt : 0;
                tries = (i == nack_idx) ? nack_cnt + RETRY : 1;
                for (int a = 0; a < tries; a++) begin
                    txn(i, a < n, have, poke && i == 1 && a == 0);
                    have = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && !error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_idx"}, 32'(reg_idx), 32'(NREG - 1));
        chk({tag, "_ena"}, 32'(ena), 32'd0);
    endtask

    task automatic powerup_from_release(input string tag);
        int cyc;
        bit ok;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        busy = 1'b0;
        wait_ena(400, cyc, ok);
        chk_range({tag, "_pwrup_lat"}, cyc + 5, PWR + 2, PWR + 4);
        chk({tag, "_first_idx"}, 32'(reg_idx), 32'd0);
    endtask

    initial begin
        int cyc;
        bit ok;
        int w;
        int ena_cnt;

        set_vec(0,  8'h12, 8'h80);
        set_vec(1,  8'h11, 8'h01);
        set_vec(2,  8'h0C, 8'h00);
        set_vec(3,  8'hFF, 8'h02);
        set_vec(4,  8'h3E, 8'h00);
        set_vec(5,  8'h40, 8'hD0);
        set_vec(6,  8'h3A, 8'h04);
        set_vec(7,  8'h14, 8'h18);
        set_vec(8,  8'h4F, 8'hB3);
        set_vec(9,  8'h50, 8'hB3);
        set_vec(10, 8'h51, 8'h00);
        set_vec(11, 8'h52, 8'h3D);
        set_vec(12, 8'h53, 8'hA7);
        set_vec(13, 8'h54, 8'hE4);
        set_vec(14, 8'h58, 8'h9E);
        set_vec(15, 8'h3D, 8'hC0);

        rst = 1'b1; start = 1'b0; busy = 1'b1; ack_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_sub", 32'(sub_addr), 32'd0);
        chk("rst_data", 32'(data_wr), 32'd0);
        chk("rst_idx", 32'(reg_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("addr", 32'(addr), 32'h42);
        chk("rw", 32'(rw), 32'd0);

        // Nominal pass from reset release
        powerup_from_release("nom");
        run_seq(NREG - 1, 1'b1, 1'b0, -1, 0);
        wait_done("nom");

        // Restart from DONE, with an ignored start during WAIT_LO of entry 1
        pulse_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        chk("restart_idx", 32'(reg_idx), 32'd0);
        run_seq(NREG - 1, 1'b0, 1'b1, -1, 0);
        wait_done("replay");

        // NACK on entry 5
        pulse_start();
        run_seq(RETRY ? NREG - 1 : 5, 1'b0, 1'b0, 5, NACKS);
        if (RETRY != 0) begin
            wait_done("retry");
        end else begin
            ena_cnt = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (ena) ena_cnt++;
            end
            chk("nack_error", 32'(error), 32'd1);
            chk("nack_idx", 32'(reg_idx), 32'd5);
            chk("nack_done", 32'(done), 32'd0);
            chk("nack_no_ena", 32'(ena_cnt), 32'd0);
        end

        // Timeout: master never raises busy on entry 0
        ack_err = 1'b0;
        pulse_start();
        wait_ena(400, cyc, ok);
        chk("to_ena_seen", 32'(ok), 32'd1);
        w = 0;
        while (ena && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk_range("to_ena_drop", w, TO - 5, TO + 3);
        chk("to_error", 32'(error), 32'd1);
        chk("to_idx", 32'(reg_idx), 32'd0);

        // Reset in the middle of entry 7
        pulse_start();
        run_seq(6, 1'b0, 1'b0, -1, 0);
        wait_ena(400, cyc, ok);
        chk("mid_idx", 32'(reg_idx), 32'd7);
        busy = 1'b1;
        @(negedge clk);
        chk("mid_ena_before", 32'(ena), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_ena_rst", 32'(ena), 32'd0);
        chk("mid_idx_rst", 32'(reg_idx), 32'd0);
        busy = 1'b1;
        ack_err = 1'b0;
        @(negedge clk);
        powerup_from_release("after_rst");
        run_seq(NREG - 1, 1'b1, 1'b0, -1, 0);
        wait_done("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
